// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline writeback vs. buffered multi-cycle results
// Optional starvation stall enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_result,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_result,
    input  logic [4:0]  src_rs,
    input  logic [4:0]  src_rt,
    output logic        hazard_o,
    output logic        stall_o,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    logic [4:0]  q_rd   [2];
    logic [31:0] q_data [2];
    logic [1:0]  q_live;
    logic        rptr;
    logic        wptr;
    logic [1:0]  count;

    logic        head_valid;
    logic        full;
    logic        push;
    logic        pipe_eff;
    logic        fifo_grant;
    logic [1:0]  slot_valid;

    assign head_valid = (count != 2'd0);
    assign full       = (count == 2'd2);
    assign mc_ready   = !rst && !full;
    assign push       = mc_valid && mc_ready;
    assign pipe_eff   = pipe_we && (pipe_rd != 5'd0) && !stall_o;
    assign fifo_grant = !pipe_eff && head_valid;

    always_comb begin
        slot_valid[0] = full || (head_valid && !rptr);
        slot_valid[1] = full || (head_valid && rptr);
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (slot_valid[i] && q_live[i] &&
                (((src_rs != 5'd0) && (src_rs == q_rd[i])) ||
                 ((src_rt != 5'd0) && (src_rt == q_rd[i]))))
                hazard_o = 1'b1;
        end
    end

`ifdef WB_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign stall_o = !rst && head_valid && (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || fifo_grant || !head_valid)
            starve_cnt <= 4'd0;
        else
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (STARVE_LIMIT == 0);
    assign stall_o    = 1'b0;
`endif

    // Payload storage carries no reset; validity is tracked by count/q_live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= mc_rd;
            q_data[wptr] <= mc_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            rptr    <= 1'b0;
            wptr    <= 1'b0;
            q_live  <= 2'b00;
            rf_we   <= 1'b0;
            rf_addr <= 5'd0;
            rf_data <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pipe_eff && slot_valid[i] && (q_rd[i] == pipe_rd))
                    q_live[i] <= 1'b0;
            end
            // A same-cycle pipe write to the same rd is younger, so the entry lands dead.
            if (push) begin
                q_live[wptr] <= (mc_rd != 5'd0) && !(pipe_eff && (mc_rd == pipe_rd));
                wptr         <= ~wptr;
            end
            if (fifo_grant)
                rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, fifo_grant};

            if (pipe_eff) begin
                rf_we   <= 1'b1;
                rf_addr <= pipe_rd;
                rf_data <= pipe_result;
            end else if (fifo_grant) begin
                rf_we <= q_live[rptr];
                if (q_live[rptr]) begin
                    rf_addr <= q_rd[rptr];
                    rf_data <= q_data[rptr];
                end
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
